// File: rtl/spi_slave_param.sv
// SPI slave front-end: receives one {cmd,payload} frame per SS_n assertion. On a read-data
// command it waits (bounded) for tx_data and shifts it out on MISO, MSB first.
module spi_slave_param #(
    parameter int DATA_W         = 8,
    parameter int TX_TIMEOUT     = 16,
    parameter bit CHECK_RD_ORDER = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    output logic              MISO,
    output logic              busy,
    output logic              err
);
    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TMO_W   = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RX, WAIT_TX, TX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [FRAME_W-2:0] shreg_q, shreg_d;
    logic [FRAME_W-1:0] rx_data_d;
    logic               rx_valid_d, miso_d, busy_d, err_d;
    logic               rd_seen_q, rd_seen_d;

    logic [FRAME_W-1:0] frame;
    logic [1:0]         cmd;
    logic               last_bit, order_bad, tmo_hit, tx_last;

    // The frame is only meaningful on the last RX sample, where MOSI supplies its LSB.
    assign frame     = {shreg_q, MOSI};
    assign cmd       = frame[FRAME_W-1 -: 2];
    assign last_bit  = (cnt_q == CNT_W'(FRAME_W - 1));
    assign order_bad = CHECK_RD_ORDER && (cmd == 2'b11) && !rd_seen_q;
    assign tmo_hit   = (tmo_q == TMO_W'(TX_TIMEOUT - 1));
    assign tx_last   = (cnt_q == CNT_W'(DATA_W));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (SS_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = RX;
                RX:      if (last_bit) state_d = (cmd == 2'b11 && !order_bad) ? WAIT_TX : DONE;
                WAIT_TX: begin
                    if (tx_valid)     state_d = TX;
                    else if (tmo_hit) state_d = DONE;
                end
                TX:      if (tx_last) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data;
        rd_seen_d  = rd_seen_q;
        rx_valid_d = 1'b0;
        err_d      = 1'b0;
        miso_d     = 1'b0;
        busy_d     = (state_d == WAIT_TX) || (state_d == TX);
        if (SS_n) begin
            // Deselect mid-transaction is an abort; an RX with nothing sampled yet is not.
            cnt_d = '0;
            tmo_d = '0;
            if ((state_q == RX && cnt_q != '0) || state_q == WAIT_TX || state_q == TX)
                err_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    tmo_d = '0;
                end
                RX: begin
                    shreg_d = frame[FRAME_W-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (last_bit) begin
                        cnt_d = '0;
                        if (order_bad) begin
                            err_d = 1'b1;
                        end else begin
                            rx_data_d  = frame;
                            rx_valid_d = 1'b1;
                            if (cmd == 2'b10)      rd_seen_d = 1'b1;
                            else if (cmd == 2'b11) rd_seen_d = 1'b0;
                        end
                    end
                end
                WAIT_TX: begin
                    if (tx_valid) begin
                        miso_d  = tx_data[DATA_W-1];
                        shreg_d = {1'b0, tx_data[DATA_W-2:0], 1'b0};
                        cnt_d   = CNT_W'(1);
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                        if (tmo_hit) err_d = 1'b1;
                    end
                end
                TX: begin
                    // cnt_q counts bits already driven; the next bit sits at shreg_q[DATA_W-1].
                    if (!tx_last) begin
                        miso_d  = shreg_q[DATA_W-1];
                        shreg_d = {1'b0, shreg_q[DATA_W-2:0], 1'b0};
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            tmo_q     <= '0;
            shreg_q   <= '0;
            rd_seen_q <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            MISO      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            shreg_q   <= shreg_d;
            rd_seen_q <= rd_seen_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            MISO      <= miso_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end
endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: three instances (default, no order check, 16-bit/short timeout)
// driven by directed and random SPI sessions, checked against a transaction-level model.
module tb_spi_slave_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  ss_n, mosi, tx_valid;
    logic [15:0] tx_data [3];
    logic [9:0]  rx_data0, rx_data1;
    logic [17:0] rx_data2;
    logic [2:0]  rxv, miso, busy, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-instance configuration and model state.
    int          dw  [3] = '{8, 8, 16};
    int          tmo [3] = '{16, 16, 4};
    bit          ord [3] = '{1'b1, 1'b0, 1'b1};
    bit          rd_seen [3];
    logic [17:0] exp_rx  [3];

    spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(16), .CHECK_RD_ORDER(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi[0]), .tx_valid(tx_valid[0]),
        .tx_data(tx_data[0][7:0]), .rx_data(rx_data0), .rx_valid(rxv[0]), .MISO(miso[0]),
        .busy(busy[0]), .err(err[0]));
    spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(16), .CHECK_RD_ORDER(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi[1]), .tx_valid(tx_valid[1]),
        .tx_data(tx_data[1][7:0]), .rx_data(rx_data1), .rx_valid(rxv[1]), .MISO(miso[1]),
        .busy(busy[1]), .err(err[1]));
    spi_slave_param #(.DATA_W(16), .TX_TIMEOUT(4), .CHECK_RD_ORDER(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n[2]), .MOSI(mosi[2]), .tx_valid(tx_valid[2]),
        .tx_data(tx_data[2]), .rx_data(rx_data2), .rx_valid(rxv[2]), .MISO(miso[2]),
        .busy(busy[2]), .err(err[2]));

    function automatic logic [17:0] get_rxd(input int s);
        case (s)
            0:       return {8'b0, rx_data0};
            1:       return {8'b0, rx_data1};
            default: return rx_data2;
        endcase
    endfunction

    task automatic chk(input string tag, input int s, input logic [17:0] obs, input logic [17:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, s, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int s, input bit e_rxv, input bit e_err,
                            input bit e_busy, input bit e_miso);
        chk({tag, ".rx_valid"}, s, 18'(rxv[s]),  18'(e_rxv));
        chk({tag, ".err"},      s, 18'(err[s]),  18'(e_err));
        chk({tag, ".busy"},     s, 18'(busy[s]), 18'(e_busy));
        chk({tag, ".miso"},     s, 18'(miso[s]), 18'(e_miso));
    endtask

    // One SS_n assertion. nbits < frame width means SS_n rises early. mode: 0 normal,
    // 1 deselect after `delay` WAIT_TX cycles, 2 deselect after `delay` MISO bits.
    task automatic session(input int s, input logic [17:0] frame, input int nbits,
                           input int delay, input logic [15:0] txd, input int mode);
        int  w, fw;
        bit  bad, want_tx;
        logic [1:0] cmd;
        w  = dw[s];
        fw = w + 2;
        @(negedge clk);
        ss_n[s] = 1'b0;
        mosi[s] = 1'($urandom_range(0, 1));
        for (int i = 0; i < nbits && i < fw; i++) begin
            @(negedge clk);
            chk_outs("rx_bit", s, 1'b0, 1'b0, 1'b0, 1'b0);
            mosi[s] = frame[fw-1-i];
        end
        @(negedge clk);
        if (nbits < fw) begin
            chk_outs("pre_abort", s, 1'b0, 1'b0, 1'b0, 1'b0);
            ss_n[s] = 1'b1;
            mosi[s] = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_outs("rx_abort", s, 1'b0, nbits > 0, 1'b0, 1'b0);
            chk("rx_abort.rx_data", s, get_rxd(s), exp_rx[s]);
            return;
        end
        cmd     = frame[fw-1 -: 2];
        bad     = ord[s] && cmd == 2'b11 && !rd_seen[s];
        want_tx = cmd == 2'b11 && !bad;
        if (!bad) begin
            exp_rx[s] = (fw == 18) ? frame : {8'b0, frame[9:0]};
            if (cmd == 2'b10)      rd_seen[s] = 1'b1;
            else if (cmd == 2'b11) rd_seen[s] = 1'b0;
        end
        chk_outs("frame_end", s, !bad, bad, want_tx, 1'b0);
        chk("frame_end.rx_data", s, get_rxd(s), exp_rx[s]);
        mosi[s] = 1'($urandom_range(0, 1));
        if (want_tx) begin
            tx_valid[s] = 1'b0;
            if (mode == 1) begin
                for (int k = 0; k < delay; k++) begin
                    @(negedge clk);
                    chk_outs("wait_pre_abort", s, 1'b0, 1'b0, 1'b1, 1'b0);
                end
                ss_n[s] = 1'b1;
                @(negedge clk);
                chk_outs("wait_abort", s, 1'b0, 1'b1, 1'b0, 1'b0);
                return;
            end else if (mode == 0 && delay >= tmo[s]) begin
                for (int k = 1; k <= tmo[s]; k++) begin
                    @(negedge clk);
                    if (k < tmo[s]) chk_outs("wait", s, 1'b0, 1'b0, 1'b1, 1'b0);
                    else            chk_outs("timeout", s, 1'b0, 1'b1, 1'b0, 1'b0);
                end
                tx_valid[s] = 1'b1;
                tx_data[s]  = 16'($urandom);
                @(negedge clk);
                chk_outs("done_after_tmo", s, 1'b0, 1'b0, 1'b0, 1'b0);
                tx_valid[s] = 1'b0;
            end else begin
                for (int k = 0; k < (mode == 2 ? 0 : delay); k++) begin
                    @(negedge clk);
                    chk_outs("wait", s, 1'b0, 1'b0, 1'b1, 1'b0);
                end
                tx_valid[s] = 1'b1;
                tx_data[s]  = txd;
                for (int j = 0; j < (mode == 2 ? delay : w); j++) begin
                    @(negedge clk);
                    tx_valid[s] = 1'($urandom_range(0, 1));
                    tx_data[s]  = 16'($urandom);
                    chk_outs("tx_bit", s, 1'b0, 1'b0, 1'b1, txd[w-1-j]);
                end
                if (mode == 2) begin
                    ss_n[s]     = 1'b1;
                    tx_valid[s] = 1'b0;
                    @(negedge clk);
                    chk_outs("tx_abort", s, 1'b0, 1'b1, 1'b0, 1'b0);
                    return;
                end
                @(negedge clk);
                tx_valid[s] = 1'b0;
                chk_outs("tx_end", s, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        ss_n[s] = 1'b1;
        @(negedge clk);
        chk_outs("deselect", s, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ss_n     = 3'b111;
        mosi     = 3'b000;
        tx_valid = 3'b000;
        for (int s = 0; s < 3; s++) begin
            tx_data[s] = '0;
            rd_seen[s] = 1'b0;
            exp_rx[s]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk_outs("reset", s, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("reset.rx_data", s, get_rxd(s), 18'h0);
        end
        rst_n = 1'b1;

        // Read-data with no prior read-address: rejected only when order checking is on.
        session(0, 18'h300, 10, 0, 16'h0, 0);
        session(1, 18'h300, 10, 16, 16'h0, 0);
        // Plain write, then a complete read with a two-cycle RAM latency.
        session(0, 18'h0A5, 10, 0, 16'h0, 0);
        session(0, 18'h23C, 10, 0, 16'h0, 0);
        session(0, 18'h3A7, 10, 2, 16'h0096, 0);
        // Abort after 5 bits, abort on the final sample, then a full frame still works.
        session(0, 18'h1FF, 5, 0, 16'h0, 0);
        session(0, 18'h1FF, 9, 0, 16'h0, 0);
        session(0, 18'h1FF, 10, 0, 16'h0, 0);
        session(0, 18'h000, 0, 0, 16'h0, 0);
        // Timeout, and the latest tx_valid that still avoids it.
        session(0, 18'h211, 10, 0, 16'h0, 0);
        session(0, 18'h300, 10, 16, 16'h0, 0);
        session(0, 18'h211, 10, 0, 16'h0, 0);
        session(0, 18'h3FF, 10, 15, 16'h005A, 0);
        // 16-bit instance.
        session(2, 18'h1BEEF, 18, 0, 16'h0, 0);
        session(2, 18'h21234, 18, 0, 16'h0, 0);
        session(2, 18'h30000, 18, 1, 16'h8001, 0);

        // Reset in the middle of a frame clears the read-order history without pulsing.
        session(0, 18'h2AA, 10, 0, 16'h0, 0);
        @(negedge clk);
        ss_n[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mosi[0] = 1'($urandom_range(0, 1));
        end
        rst_n   = 1'b0;
        ss_n[0] = 1'b1;
        @(negedge clk);
        chk_outs("mid_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_reset.rx_data", 0, get_rxd(0), 18'h0);
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            rd_seen[s] = 1'b0;
            exp_rx[s]  = '0;
        end
        @(negedge clk);
        chk_outs("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        session(0, 18'h3C3, 10, 0, 16'h0, 0);

        for (int n = 0; n < 60; n++) begin
            int          s, fw, nb, md, dl;
            logic [17:0] fr;
            s  = $urandom_range(0, 2);
            fw = dw[s] + 2;
            fr = 18'($urandom);
            if ($urandom_range(0, 2) == 0) fr[fw-1 -: 2] = 2'b10;
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, fw - 1) : fw;
            md = $urandom_range(0, 5);
            md = (md > 2) ? 0 : md;
            if (md == 1)      dl = $urandom_range(0, tmo[s] - 1);
            else if (md == 2) dl = $urandom_range(1, dw[s] - 1);
            else              dl = $urandom_range(0, tmo[s] + 1);
            session(s, fr, nb, dl, 16'($urandom), md);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
